// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types and constants for fetch/decode/execute.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned c_addr_w    = 32;
    localparam logic [31:0] c_reset_vec = 32'h0000_0000;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_arb
// Description : Fixed-priority trap/jump redirect selection with STEP masking.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_arb
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR_W = c_addr_w,
    parameter longint unsigned STEP   = 4
) (
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              redirect_en_o,
    output logic [ADDR_W-1:0] target_o,
    output logic              misaligned_o
);

    // Offset bits below the fetch granule; all-zero when STEP is 1.
    localparam logic [ADDR_W-1:0] c_low_mask = ADDR_W'(STEP - 64'd1);

    logic [ADDR_W-1:0] w_sel_addr;

    always_comb begin
        w_sel_addr = jump_addr_i;
        if (trap_en_i) begin
            w_sel_addr = trap_addr_i;
        end
    end

    assign redirect_en_o = trap_en_i | jump_en_i;
    assign target_o      = w_sel_addr & ~c_low_mask;
    assign misaligned_o  = redirect_en_o & (|(w_sel_addr & c_low_mask));

endmodule : pc_redirect_arb
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch-stage program counter with boot delay, redirects,
//               flush/misalign pulses and an accepted-fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = c_addr_w,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(c_reset_vec),
    parameter longint unsigned   STEP        = 4,
    parameter int unsigned       BOOT_CYCLES = 1,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    input  logic              fetch_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    localparam pc_state_e         c_state_rst = (BOOT_CYCLES == 0) ? RUN : BOOT;
    localparam logic [ADDR_W-1:0] c_step      = ADDR_W'(STEP);

    pc_state_e         r_state;
    pc_state_e         w_state_next;
    logic              w_boot_done;
    logic              w_fire;
    logic              w_redirect_en;
    logic [ADDR_W-1:0] w_target;
    logic              w_misaligned;
    logic [ADDR_W-1:0] r_pc;
    logic              r_flush;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_fetch_cnt;

    pc_redirect_arb #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_redirect_arb (
        .trap_en_i     (trap_en_i),
        .trap_addr_i   (trap_addr_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .redirect_en_o (w_redirect_en),
        .target_o      (w_target),
        .misaligned_o  (w_misaligned)
    );

    // Boot delay counter; counts only while in BOOT and is unaffected by redirects.
    generate
        if (BOOT_CYCLES > 0) begin : g_boot_cnt
            localparam int unsigned c_bw = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
            logic [c_bw-1:0] r_boot_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_boot_cnt <= '0;
                end else if (r_state == BOOT && !w_boot_done) begin
                    r_boot_cnt <= r_boot_cnt + 1'b1;
                end
            end

            assign w_boot_done = (r_boot_cnt == c_bw'(BOOT_CYCLES - 1));
        end else begin : g_no_boot
            assign w_boot_done = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_state_rst;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    if (w_boot_done) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = c_state_rst;
        endcase
    end

    assign fetch_valid_o = (r_state == RUN) && !hold_flag_i;
    assign w_fire        = fetch_valid_o && fetch_ready_i;

    // A redirect wins over sequential advance; the accepted address is dropped via flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VEC;
            r_flush     <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            if (w_redirect_en) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + c_step;
            end
            r_flush    <= w_redirect_en;
            r_misalign <= w_misaligned;
            if (w_fire) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    assign pc_o        = r_pc;
    assign flush_o     = r_flush;
    assign misalign_o  = r_misalign;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed self-checking bench for pc_gen (BOOT_CYCLES=2, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int unsigned c_addr_w = 32;
    localparam int unsigned c_cnt_w  = 4;

    logic                clk;
    logic                rst;
    logic                trap_en_i;
    logic [c_addr_w-1:0] trap_addr_i;
    logic                jump_en_i;
    logic [c_addr_w-1:0] jump_addr_i;
    logic                hold_flag_i;
    logic                fetch_ready_i;
    logic [c_addr_w-1:0] pc_o;
    logic                fetch_valid_o;
    logic                flush_o;
    logic                misalign_o;
    logic [c_cnt_w-1:0]  fetch_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

    pc_gen #(
        .ADDR_W      (c_addr_w),
        .RESET_VEC   (32'h0000_0000),
        .STEP        (4),
        .BOOT_CYCLES (2),
        .CNT_W       (c_cnt_w)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trap_en_i     (trap_en_i),
        .trap_addr_i   (trap_addr_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .fetch_ready_i (fetch_ready_i),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] pc, input logic valid,
                                input logic flush, input logic mis, input logic [3:0] cnt);
        check({tag, ".pc"},    64'(pc_o),          64'(pc));
        check({tag, ".valid"}, 64'(fetch_valid_o), 64'(valid));
        check({tag, ".flush"}, 64'(flush_o),       64'(flush));
        check({tag, ".mis"},   64'(misalign_o),    64'(mis));
        check({tag, ".cnt"},   64'(fetch_cnt_o),   64'(cnt));
    endtask

    initial begin
        rst = 1'b1; trap_en_i = 1'b0; trap_addr_i = '0; jump_en_i = 1'b0;
        jump_addr_i = '0; hold_flag_i = 1'b0; fetch_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        expect_state("boot1", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        expect_state("run0", 32'h0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(); expect_state("seq4",  32'h4,  1'b1, 1'b0, 1'b0, 4'd1);
        tick(); expect_state("seq8",  32'h8,  1'b1, 1'b0, 1'b0, 4'd2);
        tick(); expect_state("seq12", 32'hC,  1'b1, 1'b0, 1'b0, 4'd3);
        tick(); expect_state("seq16", 32'h10, 1'b1, 1'b0, 1'b0, 4'd4);

        fetch_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state("ready_lo", 32'h10, 1'b1, 1'b0, 1'b0, 4'd4);
        end
        fetch_ready_i = 1'b1;
        tick(); expect_state("ready_up", 32'h14, 1'b1, 1'b0, 1'b0, 4'd5);

        // Trap beats jump and overrides hold
        trap_en_i = 1'b1; trap_addr_i = 32'h200; jump_en_i = 1'b1; jump_addr_i = 32'h80;
        hold_flag_i = 1'b1;
        #1 check("hold_valid", 64'(fetch_valid_o), 64'd0);
        tick(); expect_state("trap", 32'h200, 1'b0, 1'b1, 1'b0, 4'd5);
        trap_en_i = 1'b0; jump_en_i = 1'b0; hold_flag_i = 1'b0;
        tick(); expect_state("trap_after", 32'h204, 1'b1, 1'b0, 1'b0, 4'd6);

        // Misaligned jump; handshake in redirect cycle still counts
        jump_en_i = 1'b1; jump_addr_i = 32'h103;
        tick(); expect_state("jmp_mis", 32'h100, 1'b1, 1'b1, 1'b1, 4'd7);
        jump_en_i = 1'b0;
        tick(); expect_state("jmp_after", 32'h104, 1'b1, 1'b0, 1'b0, 4'd8);

        // Misaligned jump loses to aligned trap: no misalign
        trap_en_i = 1'b1; trap_addr_i = 32'h300; jump_en_i = 1'b1; jump_addr_i = 32'h81;
        tick(); expect_state("trap_win", 32'h300, 1'b1, 1'b1, 1'b0, 4'd9);
        trap_en_i = 1'b0;

        // Back-to-back redirects
        jump_addr_i = 32'h400;
        tick(); expect_state("b2b_1", 32'h400, 1'b1, 1'b1, 1'b0, 4'd10);
        jump_addr_i = 32'h500;
        tick(); expect_state("b2b_2", 32'h500, 1'b1, 1'b1, 1'b0, 4'd11);
        jump_en_i = 1'b0;
        tick(); expect_state("b2b_end", 32'h504, 1'b1, 1'b0, 1'b0, 4'd12);

        // Address wrap and counter wrap
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        tick(); expect_state("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 4'd13);
        jump_en_i = 1'b0;
        tick(); expect_state("pc_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 4'd14);
        tick(); expect_state("cnt15", 32'h4, 1'b1, 1'b0, 1'b0, 4'd15);
        tick(); expect_state("cnt_wrap", 32'h8, 1'b1, 1'b0, 1'b0, 4'd0);

        hold_flag_i = 1'b1;
        tick(); expect_state("hold", 32'h8, 1'b0, 1'b0, 1'b0, 4'd0);
        hold_flag_i = 1'b0;

        // Reset beats a simultaneous jump; BOOT repeats
        rst = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h700;
        tick();
        rst = 1'b0; jump_en_i = 1'b0;
        expect_state("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Redirect during BOOT moves pc but does not shorten the delay
        jump_en_i = 1'b1; jump_addr_i = 32'h40;
        tick(); expect_state("boot_jmp", 32'h40, 1'b0, 1'b1, 1'b0, 4'd0);
        jump_en_i = 1'b0;
        tick(); expect_state("reboot_run", 32'h40, 1'b1, 1'b0, 1'b0, 4'd0);
        tick(); expect_state("reboot_seq", 32'h44, 1'b1, 1'b0, 1'b0, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It holds the fetch address and issues it to instruction memory over a valid/ready handshake. It redirects on trap or jump with fixed priority and signals a one-cycle flush to the fetch path on every redirect. It also provides a post-reset boot delay, redirect-alignment checking and a fetched-instruction counter.

## Interface
- ADDR_W, 32, width of the PC and redirect addresses
- RESET_VEC, 32'h0000_0000, PC value after reset; must be STEP-aligned
- STEP, 4, sequential increment in bytes; must be a power of two and at most 2^ADDR_W
- BOOT_CYCLES, 1, cycles after reset before the first fetch is offered; 0 means fetch starts the cycle after reset
- CNT_W, 32, width of the fetch counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- trap_en_i  in  1  trap or interrupt redirect request; highest priority
- trap_addr_i  in  ADDR_W  trap target
- jump_en_i  in  1  branch or jump redirect from execute
- jump_addr_i  in  ADDR_W  jump target
- hold_flag_i  in  1  pipeline stall; freezes sequential advance
- fetch_ready_i  in  1  instruction memory accepts the address
- pc_o  out  ADDR_W  current fetch address
- fetch_valid_o  out  1  pc_o is offered to instruction memory
- flush_o  out  1  one-cycle pulse: discard any in-flight fetch response
- misalign_o  out  1  one-cycle pulse: the last redirect target was not STEP-aligned
- fetch_cnt_o  out  CNT_W  number of accepted fetch handshakes, wrapping

## Operation
- States:
  - BOOT: counts BOOT_CYCLES cycles, then moves to RUN. With BOOT_CYCLES=0, reset enters RUN directly.
  - RUN: steady state.
- fetch_valid_o = (state==RUN) && !hold_flag_i. This is combinational from state and hold_flag_i; fetch_ready_i does not affect it.
- Handshake fires when fetch_valid_o && fetch_ready_i.
- Next-PC priority, evaluated every cycle in both states:
  1. trap_en_i: pc <= trap_addr_i with the low log2(STEP) bits forced to 0.
  2. jump_en_i: pc <= jump_addr_i, masked the same way.
  3. Handshake fires: pc <= pc + STEP, modulo 2^ADDR_W (wraps at the top of the address space).
  4. Otherwise pc holds. This covers hold, ready low and BOOT.
- Redirect behaviour:
  - A redirect overrides hold_flag_i and any handshake in the same cycle.
  - The address accepted in that cycle is not advanced past; its response is flushed.
  - Redirects in BOOT update pc but do not shorten or restart the boot count.
- flush_o: registered; high the cycle after any redirect, i.e. in the first cycle pc_o shows the target.
- misalign_o: registered; high in the same cycle as flush_o when the selected target had nonzero low bits. Only the selected source is checked: a misaligned jump that loses to a trap does not raise misalign_o.
- fetch_cnt_o: increments by 1 on every handshake, including a handshake in a redirect cycle. Wraps from 2^CNT_W−1 to 0.
- Reset values: pc_o=RESET_VEC, fetch_valid_o=0, flush_o=0, misalign_o=0, fetch_cnt_o=0, state=BOOT (RUN if BOOT_CYCLES=0). Reset overrides all inputs, including a redirect in the same cycle, and aborts BOOT or RUN immediately.

## Timing
- Redirect latency: 1 cycle. Redirect sampled at edge N gives pc_o = target and flush_o=1 from edge N.
- Sequential latency: a handshake at edge N gives pc_o+STEP from edge N.
- Back-to-back handshakes every cycle sustain one fetch per cycle.
- After reset deassertion, fetch_valid_o first rises BOOT_CYCLES cycles later, provided hold_flag_i is low.
- Consecutive redirects on consecutive cycles each take effect and produce flush_o high on consecutive cycles.
- The PC does not depend on fetch_ready_i combinationally; only the handshake term does.

## Structure
- Shared package cpu_pkg holds:
  - the pc_gen state enum {BOOT, RUN}
  - default RESET_VEC and ADDR_W constants shared with decode/execute
- Sub-module pc_redirect_arb:
  - inputs: trap/jump enables and addresses
  - outputs: redirect_en, masked target and misaligned flag
  - purely combinational, reused by the future branch predictor
- Top level holds the boot counter, PC register, flush/misalign registers and fetch counter.

## Test plan
- Reset, BOOT_CYCLES=2, ready=1:
  - fetch_valid_o low for 2 cycles, then pc_o goes 0, 4, 8, 12 on consecutive cycles.
  - fetch_cnt_o reads 4 after four handshakes.
- fetch_ready_i low 3 cycles at pc=0x10 -> pc_o holds 0x10 with fetch_valid_o=1; advances to 0x14 the cycle after ready rises.
- trap_en_i (0x200) and jump_en_i (0x80) in the same cycle, hold_flag_i=1 -> pc_o=0x200 next cycle, flush_o one-cycle pulse, misalign_o=0.
- jump_addr_i=0x103 -> pc_o=0x100, flush_o=1 and misalign_o=1 for exactly one cycle.
- Boundary values:
  - ADDR_W=32, pc=0xFFFF_FFFC with a handshake -> pc_o=0x0.
  - CNT_W=4 after 16 handshakes -> fetch_cnt_o=0.
- rst asserted mid-run together with jump_en_i -> pc_o=RESET_VEC, flush_o=0, fetch_valid_o=0, fetch_cnt_o=0, BOOT repeats.
